// File: rtl/decode_ctrl_pipe_pkg.sv
// Shared opcode, ALU and FSM encodings for the decode-stage control pipeline.
// Helper functions classify opcodes by register and flag usage.
package decode_ctrl_pipe_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_ADDZ = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_NOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_LW   = 4'd8,
        OP_SW   = 4'd9,
        OP_LHB  = 4'd10,
        OP_LLB  = 4'd11,
        OP_B    = 4'd12,
        OP_JAL  = 4'd13,
        OP_JR   = 4'd14,
        OP_HLT  = 4'd15
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_NOR = 4'd3,
        ALU_SLL = 4'd4,
        ALU_SRL = 4'd5,
        ALU_SRA = 4'd6,
        ALU_LHB = 4'd7,
        ALU_NOP = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    function automatic logic sets_flags(input opcode_e op);
        return op inside {OP_ADD, OP_ADDZ, OP_SUB, OP_AND, OP_NOR, OP_SLL, OP_SRL, OP_SRA};
    endfunction

    function automatic logic reads_rs1(input opcode_e op);
        return !(op inside {OP_HLT, OP_B, OP_JAL});
    endfunction

    function automatic logic reads_rs2(input opcode_e op);
        return op inside {OP_ADD, OP_ADDZ, OP_SUB, OP_AND, OP_NOR, OP_SW};
    endfunction

endpackage

// File: rtl/decode_ctrl_pipe_if.sv
// IF/ID-to-ID/EX control bus: decode-slot inputs, stall/halt status and the
// registered execute-stage control fields.
interface decode_ctrl_pipe_if #(
    parameter int REG_W   = 4,
    parameter int INSTR_W = 16
);
    logic               id_valid;
    logic [INSTR_W-1:0] id_instr;
    logic               z_flag;
    logic               flush;
    logic               stall_o;

    logic               ex_valid;
    logic [REG_W-1:0]   ex_rdReg1;
    logic [REG_W-1:0]   ex_rdReg2;
    logic [REG_W-1:0]   ex_wrReg;
    logic               ex_wrRegEn;
    logic               ex_memRd;
    logic               ex_memWr;
    logic               ex_mem2reg;
    logic               ex_aluSrc;
    logic               ex_sawBr;
    logic               ex_sawJ;
    logic               ex_setFlags;
    logic [3:0]         ex_aluOp;
    logic [3:0]         ex_shAmt;
    logic               halted_o;

    modport master (
        output id_valid, id_instr, z_flag, flush,
        input  stall_o, ex_valid, ex_rdReg1, ex_rdReg2, ex_wrReg, ex_wrRegEn,
               ex_memRd, ex_memWr, ex_mem2reg, ex_aluSrc, ex_sawBr, ex_sawJ,
               ex_setFlags, ex_aluOp, ex_shAmt, halted_o
    );

    modport slave (
        input  id_valid, id_instr, z_flag, flush,
        output stall_o, ex_valid, ex_rdReg1, ex_rdReg2, ex_wrReg, ex_wrRegEn,
               ex_memRd, ex_memWr, ex_mem2reg, ex_aluSrc, ex_sawBr, ex_sawJ,
               ex_setFlags, ex_aluOp, ex_shAmt, halted_o
    );

endinterface

// File: rtl/decode_ctrl_comb.sv
// Purely combinational instruction-to-control decode for the ID stage.
// Instruction layout: opcode | field A | field B | field C (REG_W bits each).
module decode_ctrl_comb
    import decode_ctrl_pipe_pkg::*;
#(
    parameter int REG_W    = 4,
    parameter int INSTR_W  = 4 + 3 * REG_W,
    parameter int LINK_REG = 15
) (
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               z_flag_i,
    output logic [REG_W-1:0]   rd_reg1_o,
    output logic [REG_W-1:0]   rd_reg2_o,
    output logic [REG_W-1:0]   wr_reg_o,
    output logic               rd_en1_o,
    output logic               rd_en2_o,
    output logic               wr_reg_en_o,
    output logic               mem_rd_o,
    output logic               mem_wr_o,
    output logic               mem2reg_o,
    output logic               alu_src_o,
    output logic               saw_br_o,
    output logic               saw_j_o,
    output logic               set_flags_o,
    output logic [3:0]         alu_op_o,
    output logic [3:0]         sh_amt_o
);
    opcode_e          op;
    logic [REG_W-1:0] fa;
    logic [REG_W-1:0] fb;
    logic [REG_W-1:0] fc;

    assign op = opcode_e'(instr_i[INSTR_W-1 -: 4]);
    assign fa = instr_i[3*REG_W-1 -: REG_W];
    assign fb = instr_i[2*REG_W-1 -: REG_W];
    assign fc = instr_i[REG_W-1:0];

    always_comb begin
        rd_reg1_o = fb;
        if (op == OP_LHB)
            rd_reg1_o = fa;
        else if (op == OP_LLB)
            rd_reg1_o = '0;

        // SW reads its store data from field A
        rd_reg2_o = fc;
        if (op == OP_SW)
            rd_reg2_o = fa;
        else if (op == OP_JR)
            rd_reg2_o = '0;

        wr_reg_o = fa;
        if (op == OP_JAL)
            wr_reg_o = REG_W'(LINK_REG);
        else if (op inside {OP_SW, OP_B, OP_JR, OP_HLT})
            wr_reg_o = '0;

        rd_en1_o = reads_rs1(op);
        rd_en2_o = reads_rs2(op);

        wr_reg_en_o = !(op inside {OP_HLT, OP_SW, OP_B, OP_JR});
        if (op == OP_ADDZ)
            wr_reg_en_o = z_flag_i;

        mem_rd_o  = (op == OP_LW);
        mem_wr_o  = (op == OP_SW);
        mem2reg_o = mem_rd_o;

        alu_src_o = rd_en2_o;
        if (op inside {OP_LLB, OP_SW})
            alu_src_o = 1'b0;
        else if (op == OP_JR)
            alu_src_o = 1'b1;

        saw_br_o    = (op == OP_B);
        saw_j_o     = (op inside {OP_JAL, OP_JR});
        set_flags_o = sets_flags(op);

        case (op)
            OP_ADD, OP_ADDZ, OP_LW, OP_SW, OP_LLB, OP_JR: alu_op_o = ALU_ADD;
            OP_SUB:  alu_op_o = ALU_SUB;
            OP_AND:  alu_op_o = ALU_AND;
            OP_NOR:  alu_op_o = ALU_NOR;
            OP_SLL:  alu_op_o = ALU_SLL;
            OP_SRL:  alu_op_o = ALU_SRL;
            OP_SRA:  alu_op_o = ALU_SRA;
            OP_LHB:  alu_op_o = ALU_LHB;
            default: alu_op_o = ALU_NOP;
        endcase

        sh_amt_o = instr_i[3:0];
    end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Registered decode stage: hazard detection, bubble/flush insertion, ID/EX control
// register and the HLT drain state machine.
module decode_ctrl_pipe
    import decode_ctrl_pipe_pkg::*;
#(
    parameter int REG_W     = 4,
    parameter int INSTR_W   = 16,
    parameter int DRAIN_CYC = 3,
    parameter int LINK_REG  = 15
) (
    input  logic              clk,
    input  logic              rst,
    decode_ctrl_pipe_if.slave bus
);
    localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    generate
        if (INSTR_W != 4 + 3 * REG_W) begin : g_bad_instr_w
            $error("decode_ctrl_pipe: INSTR_W must equal 4 + 3*REG_W");
        end
        if (DRAIN_CYC < 1) begin : g_bad_drain
            $error("decode_ctrl_pipe: DRAIN_CYC must be at least 1");
        end
    endgenerate

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd1;
        logic [REG_W-1:0] rd2;
        logic [REG_W-1:0] wr;
        logic             wr_en;
        logic             mem_rd;
        logic             mem_wr;
        logic             mem2reg;
        logic             alu_src;
        logic             saw_br;
        logic             saw_j;
        logic             set_flags;
        logic [3:0]       alu_op;
        logic [3:0]       sh_amt;
    } ex_ctl_t;

    logic [REG_W-1:0] dec_rd1;
    logic [REG_W-1:0] dec_rd2;
    logic [REG_W-1:0] dec_wr;
    logic             dec_rd_en1;
    logic             dec_rd_en2;
    logic             dec_wr_en;
    logic             dec_mem_rd;
    logic             dec_mem_wr;
    logic             dec_mem2reg;
    logic             dec_alu_src;
    logic             dec_saw_br;
    logic             dec_saw_j;
    logic             dec_set_flags;
    logic [3:0]       dec_alu_op;
    logic [3:0]       dec_sh_amt;

    decode_ctrl_comb #(
        .REG_W    (REG_W),
        .INSTR_W  (INSTR_W),
        .LINK_REG (LINK_REG)
    ) u_decode (
        .instr_i     (bus.id_instr),
        .z_flag_i    (bus.z_flag),
        .rd_reg1_o   (dec_rd1),
        .rd_reg2_o   (dec_rd2),
        .wr_reg_o    (dec_wr),
        .rd_en1_o    (dec_rd_en1),
        .rd_en2_o    (dec_rd_en2),
        .wr_reg_en_o (dec_wr_en),
        .mem_rd_o    (dec_mem_rd),
        .mem_wr_o    (dec_mem_wr),
        .mem2reg_o   (dec_mem2reg),
        .alu_src_o   (dec_alu_src),
        .saw_br_o    (dec_saw_br),
        .saw_j_o     (dec_saw_j),
        .set_flags_o (dec_set_flags),
        .alu_op_o    (dec_alu_op),
        .sh_amt_o    (dec_sh_amt)
    );

    ex_ctl_t          ex_d;
    ex_ctl_t          ex_q;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             halted_q;

    opcode_e id_op;
    logic    load_use;
    logic    flag_stall;
    logic    hazard;
    logic    running;
    logic    stall;
    logic    issue;

    assign id_op = opcode_e'(bus.id_instr[INSTR_W-1 -: 4]);

    // Register 0 is never a real load destination, so it cannot create a hazard.
    assign load_use = ex_q.valid && ex_q.mem_rd && (ex_q.wr != '0) &&
                      ((dec_rd_en1 && (dec_rd1 == ex_q.wr)) ||
                       (dec_rd_en2 && (dec_rd2 == ex_q.wr)));
    // ADDZ must see the Z produced by the flag setter ahead of it.
    assign flag_stall = (id_op == OP_ADDZ) && ex_q.valid && ex_q.set_flags;
    assign hazard     = bus.id_valid && (load_use || flag_stall);
    assign running    = (state_q == ST_RUN);
    assign stall      = !bus.flush && (!running || hazard);
    assign issue      = running && !bus.flush && bus.id_valid && !hazard;

    always_comb begin
        ex_d        = '0;
        ex_d.alu_op = ALU_NOP;
        if (issue) begin
            ex_d.valid     = 1'b1;
            ex_d.rd1       = dec_rd1;
            ex_d.rd2       = dec_rd2;
            ex_d.wr        = dec_wr;
            ex_d.wr_en     = dec_wr_en;
            ex_d.mem_rd    = dec_mem_rd;
            ex_d.mem_wr    = dec_mem_wr;
            ex_d.mem2reg   = dec_mem2reg;
            ex_d.alu_src   = dec_alu_src;
            ex_d.saw_br    = dec_saw_br;
            ex_d.saw_j     = dec_saw_j;
            ex_d.set_flags = dec_set_flags;
            ex_d.alu_op    = dec_alu_op;
            ex_d.sh_amt    = dec_sh_amt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q        <= '0;
            ex_q.alu_op <= ALU_NOP;
        end else begin
            ex_q <= ex_d;
        end
    end

    // HLT issues itself as a valid no-op; DRAIN then lets older work retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (issue && (id_op == OP_HLT)) begin
                        state_q <= ST_DRAIN;
                        cnt_q   <= CNT_W'(DRAIN_CYC - 1);
                    end
                end
                ST_DRAIN: begin
                    if (bus.flush) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                    end else if (cnt_q == '0) begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_HALTED: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q  <= ST_RUN;
                    cnt_q    <= '0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stall_o     = stall;
    assign bus.ex_valid    = ex_q.valid;
    assign bus.ex_rdReg1   = ex_q.rd1;
    assign bus.ex_rdReg2   = ex_q.rd2;
    assign bus.ex_wrReg    = ex_q.wr;
    assign bus.ex_wrRegEn  = ex_q.wr_en;
    assign bus.ex_memRd    = ex_q.mem_rd;
    assign bus.ex_memWr    = ex_q.mem_wr;
    assign bus.ex_mem2reg  = ex_q.mem2reg;
    assign bus.ex_aluSrc   = ex_q.alu_src;
    assign bus.ex_sawBr    = ex_q.saw_br;
    assign bus.ex_sawJ     = ex_q.saw_j;
    assign bus.ex_setFlags = ex_q.set_flags;
    assign bus.ex_aluOp    = ex_q.alu_op;
    assign bus.ex_shAmt    = ex_q.sh_amt;
    assign bus.halted_o    = halted_q;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed self-checking bench for decode_ctrl_pipe: decode fields, load-use and
// flag stalls, flush priority, HLT drain and asynchronous reset.
module tb_decode_ctrl_pipe;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    decode_ctrl_pipe_if #(.REG_W(4), .INSTR_W(16)) bus ();

    decode_ctrl_pipe #(
        .REG_W     (4),
        .INSTR_W   (16),
        .DRAIN_CYC (3),
        .LINK_REG  (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // valid | rd1 | rd2 | wr | wrEn memRd memWr mem2reg aluSrc sawBr sawJ setFlags | aluOp
    wire [24:0] ex_ctl = {bus.ex_valid, bus.ex_rdReg1, bus.ex_rdReg2, bus.ex_wrReg,
                          bus.ex_wrRegEn, bus.ex_memRd, bus.ex_memWr, bus.ex_mem2reg,
                          bus.ex_aluSrc, bus.ex_sawBr, bus.ex_sawJ, bus.ex_setFlags,
                          bus.ex_aluOp};
    wire [1:0]  st_hl  = {bus.stall_o, bus.halted_o};

    localparam logic [24:0] BUBBLE = {21'd0, 4'hF};

    function automatic logic [24:0] exp_ctl(input logic v, input logic [3:0] r1,
                                            input logic [3:0] r2, input logic [3:0] w,
                                            input logic [7:0] f, input logic [3:0] op);
        return {v, r1, r2, w, f, op};
    endfunction

    task automatic drive(input logic v, input logic [15:0] ins, input logic z, input logic fl);
        bus.id_valid = v;
        bus.id_instr = ins;
        bus.z_flag   = z;
        bus.flush    = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        tick();
        tests_run++;
        if (ex_ctl !== BUBBLE) begin
            tests_failed++;
            $display("FAIL reset_ex: got %h expected %h", ex_ctl, BUBBLE);
        end
        tests_run++;
        if (bus.ex_shAmt !== 4'h0) begin
            tests_failed++;
            $display("FAIL reset_shamt: got %h expected 0", bus.ex_shAmt);
        end
        tests_run++;
        if (st_hl !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_stall_halt: got %b expected 00", st_hl);
        end
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        logic [24:0] e;
        drive(1'b1, 16'h8310, 1'b0, 1'b0);          // LW R3,R1,0
        tick();
        e = exp_ctl(1'b1, 4'd1, 4'd0, 4'd3, 8'b1101_0000, 4'h0);
        tests_run++;
        if (ex_ctl !== e) begin
            tests_failed++;
            $display("FAIL lu_lw_issue: got %h expected %h", ex_ctl, e);
        end
        drive(1'b1, 16'h0432, 1'b0, 1'b0);          // ADD R4,R3,R2
        tests_run++;
        if (bus.stall_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL lu_stall: got %b expected 1", bus.stall_o);
        end
        tick();
        tests_run++;
        if (ex_ctl !== BUBBLE) begin
            tests_failed++;
            $display("FAIL lu_bubble: got %h expected %h", ex_ctl, BUBBLE);
        end
        tests_run++;
        if (bus.stall_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL lu_stall_one_cycle: got %b expected 0", bus.stall_o);
        end
        tick();
        e = exp_ctl(1'b1, 4'd3, 4'd2, 4'd4, 8'b1000_1001, 4'h0);
        tests_run++;
        if (ex_ctl !== e) begin
            tests_failed++;
            $display("FAIL lu_add_issue: got %h expected %h", ex_ctl, e);
        end
        drive(1'b1, 16'h8610, 1'b0, 1'b0);          // LW R6,R1,0
        tick();
        drive(1'b1, 16'h2516, 1'b0, 1'b0);          // SUB R5,R1,R6
        tests_run++;
        if (bus.stall_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL lu_stall_rs2: got %b expected 1", bus.stall_o);
        end
        tick();
        tick();
        e = exp_ctl(1'b1, 4'd1, 4'd6, 4'd5, 8'b1000_1001, 4'h1);
        tests_run++;
        if (ex_ctl !== e) begin
            tests_failed++;
            $display("FAIL lu_sub_issue: got %h expected %h", ex_ctl, e);
        end
    endtask

    task automatic test_no_stall_and_flag();
        logic [24:0] e;
        drive(1'b1, 16'h8010, 1'b0, 1'b0);          // LW R0,R1,0
        tick();
        drive(1'b1, 16'h0400, 1'b0, 1'b0);          // ADD R4,R0,R0
        tests_run++;
        if (bus.stall_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_stall_r0: got %b expected 0", bus.stall_o);
        end
        tick();
        e = exp_ctl(1'b1, 4'd0, 4'd0, 4'd4, 8'b1000_1001, 4'h0);
        tests_run++;
        if (ex_ctl !== e) begin
            tests_failed++;
            $display("FAIL r0_add_issue: got %h expected %h", ex_ctl, e);
        end
        drive(1'b1, 16'h1512, 1'b0, 1'b0);          // ADDZ R5,R1,R2, Z=0
        tests_run++;
        if (bus.stall_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL flag_stall: got %b expected 1", bus.stall_o);
        end
        tick();
        tests_run++;
        if (ex_ctl !== BUBBLE) begin
            tests_failed++;
            $display("FAIL flag_bubble: got %h expected %h", ex_ctl, BUBBLE);
        end
        tests_run++;
        if (bus.stall_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL flag_stall_one_cycle: got %b expected 0", bus.stall_o);
        end
        tick();
        e = exp_ctl(1'b1, 4'd1, 4'd2, 4'd5, 8'b0000_1001, 4'h0);
        tests_run++;
        if (ex_ctl !== e) begin
            tests_failed++;
            $display("FAIL addz_z0: got %h expected %h", ex_ctl, e);
        end
        drive(1'b1, 16'h1512, 1'b0, 1'b0);          // stalled behind ADDZ; Z changes before issue
        tick();
        drive(1'b1, 16'h1512, 1'b1, 1'b0);
        tick();
        e = exp_ctl(1'b1, 4'd1, 4'd2, 4'd5, 8'b1000_1001, 4'h0);
        tests_run++;
        if (ex_ctl !== e) begin
            tests_failed++;
            $display("FAIL addz_z1: got %h expected %h", ex_ctl, e);
        end
        drive(1'b1, 16'h8710, 1'b0, 1'b0);          // LW R7,R1,0
        tick();
        drive(1'b1, 16'hC077, 1'b0, 1'b0);          // B with fields = 7, no register reads
        tests_run++;
        if (bus.stall_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_stall_branch: got %b expected 0", bus.stall_o);
        end
        tick();
        e = exp_ctl(1'b1, 4'd7, 4'd7, 4'd0, 8'b0000_0100, 4'hF);
        tests_run++;
        if (ex_ctl !== e) begin
            tests_failed++;
            $display("FAIL branch_issue: got %h expected %h", ex_ctl, e);
        end
    endtask

    task automatic test_decode();
        logic [15:0] ins [7];
        logic [24:0] ex  [7];
        ins[0] = 16'hD234; ex[0] = exp_ctl(1'b1, 4'd3, 4'd4, 4'd15, 8'b1000_0010, 4'hF); // JAL
        ins[1] = 16'hE234; ex[1] = exp_ctl(1'b1, 4'd3, 4'd0, 4'd0,  8'b0000_1010, 4'h0); // JR
        ins[2] = 16'h9234; ex[2] = exp_ctl(1'b1, 4'd3, 4'd2, 4'd0,  8'b0010_0000, 4'h0); // SW
        ins[3] = 16'hC234; ex[3] = exp_ctl(1'b1, 4'd3, 4'd4, 4'd0,  8'b0000_0100, 4'hF); // B
        ins[4] = 16'hA234; ex[4] = exp_ctl(1'b1, 4'd2, 4'd4, 4'd2,  8'b1000_0000, 4'h7); // LHB
        ins[5] = 16'hB234; ex[5] = exp_ctl(1'b1, 4'd0, 4'd4, 4'd2,  8'b1000_0000, 4'h0); // LLB
        ins[6] = 16'h7235; ex[6] = exp_ctl(1'b1, 4'd3, 4'd5, 4'd2,  8'b1000_0001, 4'h6); // SRA
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, ins[i], 1'b0, 1'b0);
            tick();
            tests_run++;
            if (ex_ctl !== ex[i]) begin
                tests_failed++;
                $display("FAIL decode_%0d (instr %h): got %h expected %h", i, ins[i], ex_ctl, ex[i]);
            end
        end
        tests_run++;
        if (bus.ex_shAmt !== 4'h5) begin
            tests_failed++;
            $display("FAIL decode_shamt: got %h expected 5", bus.ex_shAmt);
        end
        drive(1'b0, 16'h0432, 1'b0, 1'b0);
        tests_run++;
        if (bus.stall_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL invalid_no_stall: got %b expected 0", bus.stall_o);
        end
        tick();
        tests_run++;
        if (ex_ctl !== BUBBLE) begin
            tests_failed++;
            $display("FAIL invalid_bubble: got %h expected %h", ex_ctl, BUBBLE);
        end
    endtask

    task automatic test_flush();
        logic [24:0] e;
        drive(1'b1, 16'hF000, 1'b0, 1'b1);          // HLT squashed by flush
        tests_run++;
        if (bus.stall_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_hlt_stall: got %b expected 0", bus.stall_o);
        end
        tick();
        tests_run++;
        if (ex_ctl !== BUBBLE) begin
            tests_failed++;
            $display("FAIL flush_hlt_bubble: got %h expected %h", ex_ctl, BUBBLE);
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        tests_run++;
        if (st_hl !== 2'b00) begin
            tests_failed++;
            $display("FAIL flush_hlt_still_run: got %b expected 00", st_hl);
        end
        drive(1'b1, 16'h8310, 1'b0, 1'b0);          // LW R3 then dependent ADD under flush
        tick();
        drive(1'b1, 16'h0432, 1'b0, 1'b1);
        tests_run++;
        if (bus.stall_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_over_hazard: got %b expected 0", bus.stall_o);
        end
        tick();
        tests_run++;
        if (ex_ctl !== BUBBLE) begin
            tests_failed++;
            $display("FAIL flush_hazard_bubble: got %h expected %h", ex_ctl, BUBBLE);
        end
        drive(1'b1, 16'hF000, 1'b0, 1'b0);
        tick();
        e = exp_ctl(1'b1, 4'd0, 4'd0, 4'd0, 8'b0000_0000, 4'hF);
        tests_run++;
        if (ex_ctl !== e) begin
            tests_failed++;
            $display("FAIL hlt_issue: got %h expected %h", ex_ctl, e);
        end
        tests_run++;
        if (bus.stall_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL drain_stall: got %b expected 1", bus.stall_o);
        end
        drive(1'b1, 16'hF000, 1'b0, 1'b1);
        tests_run++;
        if (bus.stall_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain_flush_stall: got %b expected 0", bus.stall_o);
        end
        tick();
        drive(1'b1, 16'h0432, 1'b0, 1'b0);
        tests_run++;
        if (st_hl !== 2'b00) begin
            tests_failed++;
            $display("FAIL run_after_flush: got %b expected 00", st_hl);
        end
        tick();
        e = exp_ctl(1'b1, 4'd3, 4'd2, 4'd4, 8'b1000_1001, 4'h0);
        tests_run++;
        if (ex_ctl !== e) begin
            tests_failed++;
            $display("FAIL issue_after_flush: got %h expected %h", ex_ctl, e);
        end
    endtask

    task automatic test_halt_drain();
        drive(1'b1, 16'hF000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0432, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (st_hl !== 2'b10) begin
                tests_failed++;
                $display("FAIL drain_%0d_stall_halt: got %b expected 10", i, st_hl);
            end
            tick();
            tests_run++;
            if (ex_ctl !== BUBBLE) begin
                tests_failed++;
                $display("FAIL drain_%0d_bubble: got %h expected %h", i, ex_ctl, BUBBLE);
            end
        end
        for (int i = 0; i < 20; i++) begin
            tests_run++;
            if (st_hl !== 2'b11 || ex_ctl !== BUBBLE) begin
                tests_failed++;
                $display("FAIL halted_%0d: got stall/halt %b ex %h expected 11 %h",
                         i, st_hl, ex_ctl, BUBBLE);
            end
            tick();
        end
    endtask

    task automatic test_reset_async();
        logic [24:0] e;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        tests_run++;
        if (st_hl !== 2'b00 || ex_ctl !== BUBBLE) begin
            tests_failed++;
            $display("FAIL async_rst_halted: got stall/halt %b ex %h expected 00 %h",
                     st_hl, ex_ctl, BUBBLE);
        end
        rst = 1'b0;
        drive(1'b1, 16'h8310, 1'b0, 1'b0);          // LW R3 then stalled ADD, reset mid-stall
        tick();
        drive(1'b1, 16'h0432, 1'b0, 1'b0);
        tests_run++;
        if (bus.stall_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_rst_stall: got %b expected 1", bus.stall_o);
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (st_hl !== 2'b00 || ex_ctl !== BUBBLE || bus.ex_shAmt !== 4'h0) begin
            tests_failed++;
            $display("FAIL async_rst_stall: got stall/halt %b ex %h sh %h expected 00 %h 0",
                     st_hl, ex_ctl, bus.ex_shAmt, BUBBLE);
        end
        rst = 1'b0;
        tick();
        e = exp_ctl(1'b1, 4'd3, 4'd2, 4'd4, 8'b1000_1001, 4'h0);
        tests_run++;
        if (ex_ctl !== e) begin
            tests_failed++;
            $display("FAIL issue_after_rst: got %h expected %h", ex_ctl, e);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall_and_flag();
        test_decode();
        test_flush();
        test_halt_drain();
        test_reset_async();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
